// File: rtl/mem_arb3.sv
// Three-port memory arbiter (ic, dc, dbg) that serialises requests and write beats onto one memory channel.
// Optional: define MEM_ARB_FIXED_PRIO_EN for fixed priority dc > ic > dbg instead of round-robin.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module mem_arb3 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int WBEATS          = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  // instruction cache
  input  logic                        ic_req_valid,
  output logic                        ic_req_ready,
  input  logic [`MEM_ADDR_BITS-1:0]   ic_req_addr,
  output logic                        ic_resp_valid,
  // data cache
  input  logic                        dc_req_valid,
  output logic                        dc_req_ready,
  input  logic                        dc_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic                        dc_data_valid,
  output logic                        dc_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]   dc_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0] dc_data_mask,
  output logic                        dc_resp_valid,
  // debug / loader
  input  logic                        dbg_req_valid,
  output logic                        dbg_req_ready,
  input  logic                        dbg_req_rw,
  input  logic [`MEM_ADDR_BITS-1:0]   dbg_req_addr,
  input  logic                        dbg_data_valid,
  output logic                        dbg_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]   dbg_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0] dbg_data_mask,
  output logic                        dbg_resp_valid,
  // memory
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_rw,
  output logic [`MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic [`MEM_TAG_BITS-1:0]    mem_req_tag,
  output logic                        mem_req_data_valid,
  input  logic                        mem_req_data_ready,
  output logic [`MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [`MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic [1:0]                  mem_req_data_offset,
  input  logic                        mem_resp_valid,
  input  logic [`MEM_TAG_BITS-1:0]    mem_resp_tag
);
  localparam int NREQ = 3;
  localparam int AW   = `MEM_ADDR_BITS;
  localparam int DW   = `MEM_DATA_BITS;
  localparam int MW   = `MEM_DATA_BITS/8;
  localparam int TW   = `MEM_TAG_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;

  localparam logic [1:0] BEAT_LAST = 2'(WBEATS-1);
  localparam logic [3:0] OUT_MAX   = 4'(MAX_OUTSTANDING);

  typedef struct packed {
    logic          vld;
    logic          rw;
    logic [AW-1:0] addr;
  } req_t;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] bits;
    logic [MW-1:0] mask;
  } wdat_t;

  req_t  [NREQ-1:0] req;
  wdat_t [NREQ-1:0] wd;

  // ic is read-only and has no data channel
  assign req[0] = {ic_req_valid, 1'b0, ic_req_addr};
  assign req[1] = {dc_req_valid, dc_req_rw, dc_req_addr};
  assign req[2] = {dbg_req_valid, dbg_req_rw, dbg_req_addr};
  assign wd[0]  = '0;
  assign wd[1]  = {dc_data_valid, dc_data_bits, dc_data_mask};
  assign wd[2]  = {dbg_data_valid, dbg_data_bits, dbg_data_mask};

  logic [1:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] beat_q, beat_d;
  logic [3:0] out_q, out_d;

  req_t  cur;
  wdat_t curd;

  always_comb begin
    cur  = '0;
    curd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == 2'(i)) begin
        cur  = req[i];
        curd = wd[i];
      end
    end
  end

  // reads are held back at the outstanding limit; writes never are
  logic            rd_ok;
  logic [NREQ-1:0] elig;
  assign rd_ok = (out_q < OUT_MAX);

  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign elig[i] = req[i].vld && (req[i].rw || rd_ok);
  end

  logic       sel_vld;
  logic [1:0] sel_id;
  assign sel_vld = |elig;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_id = 2'd0;
    if (elig[1])      sel_id = 2'd1;
    else if (elig[0]) sel_id = 2'd0;
    else if (elig[2]) sel_id = 2'd2;
  end
`else
  logic [1:0] rr_q, rr_d;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s -= NREQ;
    return 2'(s);
  endfunction

  // descending scan so the candidate nearest the pointer wins
  always_comb begin
    sel_id = 2'd0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig[rr_idx(rr_q, k)]) sel_id = rr_idx(rr_q, k);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && sel_vld) rr_d = (sel_id == 2'd2) ? 2'd0 : sel_id + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 2'd0;
    else       rr_q <= rr_d;
  end
`endif

  logic req_hs, beat_hs, rd_hs;
  assign req_hs  = (state_q == REQ) && mem_req_ready;
  assign beat_hs = (state_q == WDATA) && curd.vld && mem_req_data_ready;
  assign rd_hs   = req_hs && !cur.rw;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d   = sel_id;
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_hs) begin
          state_d = cur.rw ? WDATA : IDLE;
          beat_d  = 2'd0;
        end
      end
      WDATA: begin
        if (beat_hs) begin
          if (beat_q == BEAT_LAST) begin
            state_d = IDLE;
            beat_d  = 2'd0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // simultaneous issue and return cancel; saturate at 0 against stale responses after reset
  always_comb begin
    out_d = out_q;
    if (rd_hs && !mem_resp_valid)                     out_d = out_q + 4'd1;
    else if (!rd_hs && mem_resp_valid && out_q != '0) out_d = out_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      beat_q  <= 2'd0;
      out_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
    end
  end

  assign mem_req_valid       = (state_q == REQ);
  assign mem_req_rw          = cur.rw;
  assign mem_req_addr        = cur.addr;
  assign mem_req_tag         = TW'(gnt_q);
  assign mem_req_data_valid  = (state_q == WDATA) && curd.vld;
  assign mem_req_data_bits   = curd.bits;
  assign mem_req_data_mask   = curd.mask;
  assign mem_req_data_offset = beat_q;

  logic [NREQ-1:0] req_rdy, resp_vld;
  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign req_rdy[i]  = req_hs && (gnt_q == 2'(i));
    assign resp_vld[i] = !reset && mem_resp_valid && (mem_resp_tag[1:0] == 2'(i));
  end

  assign ic_req_ready   = req_rdy[0];
  assign dc_req_ready   = req_rdy[1];
  assign dbg_req_ready  = req_rdy[2];
  assign ic_resp_valid  = resp_vld[0];
  assign dc_resp_valid  = resp_vld[1];
  assign dbg_resp_valid = resp_vld[2];
  assign dc_data_ready  = (state_q == WDATA) && (gnt_q == 2'd1) && mem_req_data_ready;
  assign dbg_data_ready = (state_q == WDATA) && (gnt_q == 2'd2) && mem_req_data_ready;

  logic unused_tag;
  assign unused_tag = ^mem_resp_tag;

endmodule

// File: tb/tb_mem_arb3.sv
// Scoreboard bench for mem_arb3: expected requests/beats queued at stimulus, checked on memory handshakes.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module tb_mem_arb3;
  localparam int AW = `MEM_ADDR_BITS;
  localparam int DW = `MEM_DATA_BITS;
  localparam int MW = `MEM_DATA_BITS/8;
  localparam int TW = `MEM_TAG_BITS;
  localparam int WBEATS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]    v_req_valid, v_req_rw, v_data_valid;
  logic [AW-1:0] v_req_addr  [3];
  logic [DW-1:0] v_data_bits [3];
  logic [MW-1:0] v_data_mask [3];
  logic          mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [TW-1:0] mem_resp_tag;

  logic          ic_req_ready, ic_resp_valid;
  logic          dc_req_ready, dc_data_ready, dc_resp_valid;
  logic          dbg_req_ready, dbg_data_ready, dbg_resp_valid;
  logic          mem_req_valid, mem_req_rw, mem_req_data_valid;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic [1:0]    mem_req_data_offset;

  logic [2:0] o_req_ready, o_resp_valid, o_data_ready;
  assign o_req_ready  = {dbg_req_ready, dc_req_ready, ic_req_ready};
  assign o_resp_valid = {dbg_resp_valid, dc_resp_valid, ic_resp_valid};
  assign o_data_ready = {dbg_data_ready, dc_data_ready, 1'b0};

  mem_arb3 #(.MAX_OUTSTANDING(4), .WBEATS(WBEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(v_req_valid[0]), .ic_req_ready(ic_req_ready), .ic_req_addr(v_req_addr[0]),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(v_req_valid[1]), .dc_req_ready(dc_req_ready), .dc_req_rw(v_req_rw[1]),
    .dc_req_addr(v_req_addr[1]), .dc_data_valid(v_data_valid[1]), .dc_data_ready(dc_data_ready),
    .dc_data_bits(v_data_bits[1]), .dc_data_mask(v_data_mask[1]), .dc_resp_valid(dc_resp_valid),
    .dbg_req_valid(v_req_valid[2]), .dbg_req_ready(dbg_req_ready), .dbg_req_rw(v_req_rw[2]),
    .dbg_req_addr(v_req_addr[2]), .dbg_data_valid(v_data_valid[2]), .dbg_data_ready(dbg_data_ready),
    .dbg_data_bits(v_data_bits[2]), .dbg_data_mask(v_data_mask[2]), .dbg_resp_valid(dbg_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_req_data_offset(mem_req_data_offset),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0]   exp_req [$];
  logic [1:0]    exp_off [$];
  logic [DW-1:0] exp_dat [$];

  function automatic logic [63:0] rq(input logic rw, input logic [AW-1:0] a, input int id);
    return 64'({rw, a, TW'(id)});
  endfunction

  task automatic push_beats(input logic [DW-1:0] base);
    for (int b = 0; b < WBEATS; b++) begin
      exp_off.push_back(2'(b));
      exp_dat.push_back(base + DW'(b));
    end
  endtask

  // scoreboard side: every memory-side handshake must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) chk("req_unexp", 64'({mem_req_rw, mem_req_addr, mem_req_tag}), 64'hdead);
        else begin
          chk("req", 64'({mem_req_rw, mem_req_addr, mem_req_tag}), exp_req.pop_front());
          if (!mem_req_rw) chk("rd_during_wdata", 64'(exp_off.size()), 64'd0);
        end
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        if (exp_off.size() == 0) chk("beat_unexp", 64'(mem_req_data_offset), 64'hdead);
        else begin
          chk("beat_off", 64'(mem_req_data_offset), 64'(exp_off.pop_front()));
          chk("beat_data", mem_req_data_bits, exp_dat.pop_front());
        end
      end
    end
  end

  task automatic wait_req(input int p);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_req_ready[p] && n < 200);
    chk("req_wait", 64'(o_req_ready[p]), 64'd1);
    @(posedge clk); #1;
    v_req_valid[p] = 1'b0;
  endtask

  // data-ready follows 1,0,1,1,1 then stays high
  task automatic send_beats(input int p, input logic [DW-1:0] base);
    int b = 0;
    int k = 0;
    logic [4:0] pat = 5'b11101;
    v_data_valid[p] = 1'b1;
    while (b < WBEATS && k < 50) begin
      mem_req_data_ready = (k < 5) ? pat[k] : 1'b1;
      v_data_bits[p] = base + DW'(b);
      @(negedge clk);
      if (o_data_ready[p]) b++;
      @(posedge clk); #1;
      k++;
    end
    chk("beat_count", 64'(b), 64'(WBEATS));
    v_data_valid[p] = 1'b0;
    mem_req_data_ready = 1'b1;
  endtask

  task automatic resp(input int t);
    logic [2:0] e;
    e = (t < 3) ? 3'(1 << t) : 3'b000;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = TW'(t);
    @(negedge clk);
    chk($sformatf("resp_tag%0d", t), 64'(o_resp_valid), 64'(e));
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  task automatic expect_blocked(input string tag, input int p);
    int hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_req_ready[p]) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int h;
    int n;
    reset = 1'b1;
    v_req_valid = 3'b111; v_req_rw = 3'b000; v_data_valid = 3'b110;
    for (int i = 0; i < 3; i++) begin
      v_req_addr[i] = '0; v_data_bits[i] = '0; v_data_mask[i] = '1;
    end
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = TW'(1);

    // everything quiet while held in reset, even with live inputs
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_ready", 64'(o_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_data", 64'({mem_req_data_valid, dc_data_ready, dbg_data_ready}), 64'd0);
    v_req_valid = '0; v_data_valid = '0; mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // single ic read: grant latched in IDLE, request one cycle later
    exp_req.push_back(rq(1'b0, AW'('h100), 0));
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h100);
    @(negedge clk);
    chk("ic_idle_cycle", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    chk("ic_req_valid", 64'(mem_req_valid), 64'd1);
    chk("ic_ready_pulse", 64'(ic_req_ready), 64'd1);
    @(posedge clk); #1;
    v_req_valid[0] = 1'b0;
    @(negedge clk);
    chk("ic_ready_drop", 64'(ic_req_ready), 64'd0);

    // dc write with ic waiting behind it
    @(posedge clk); #1;
    exp_req.push_back(rq(1'b1, AW'('h200), 1));
    exp_req.push_back(rq(1'b0, AW'('h300), 0));
    push_beats(DW'('hA0));
    v_req_valid[1] = 1'b1; v_req_rw[1] = 1'b1; v_req_addr[1] = AW'('h200);
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h300);
    wait_req(1);
    send_beats(1, DW'('hA0));
    wait_req(0);

    // response decode: 1 -> dc, 2 -> dbg, 3 -> nobody, 0 -> ic
    resp(1);
    resp(2);
    resp(3);
    resp(0);

    // reset in REQ abandons the dc write
    mem_req_ready = 1'b0;
    v_req_valid[1] = 1'b1; v_req_rw[1] = 1'b1; v_req_addr[1] = AW'('h600);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req_valid && n < 50);
    chk("abort_in_req", 64'(mem_req_valid), 64'd1);
    reset = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    chk("abort_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("abort_req_ready", 64'(o_req_ready), 64'd0);
    v_req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", 64'(mem_req_valid), 64'd0);

    // all three reading continuously
    @(posedge clk); #1;
    v_req_addr[0] = AW'('h400); v_req_addr[1] = AW'('h410); v_req_addr[2] = AW'('h420);
    v_req_rw = 3'b000;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) exp_req.push_back(rq(1'b0, AW'('h410), 1));
`else
    exp_req.push_back(rq(1'b0, AW'('h400), 0));
    exp_req.push_back(rq(1'b0, AW'('h410), 1));
    exp_req.push_back(rq(1'b0, AW'('h420), 2));
    exp_req.push_back(rq(1'b0, AW'('h400), 0));
`endif
    v_req_valid = 3'b111;
    h = 0; n = 0;
    while (h < 4 && n < 100) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) h++;
      n++;
    end
    chk("rr_grants", 64'(h), 64'd4);
    @(posedge clk); #1;
    v_req_valid = 3'b000;

    // four reads outstanding: reads stall, a write still goes
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h500);
    expect_blocked("rd_at_limit", 0);
    exp_req.push_back(rq(1'b1, AW'('h520), 2));
    push_beats(DW'('hB0));
    v_req_valid[2] = 1'b1; v_req_rw[2] = 1'b1; v_req_addr[2] = AW'('h520);
    wait_req(2);
    send_beats(2, DW'('hB0));
    exp_req.push_back(rq(1'b0, AW'('h500), 0));
    resp(0);
    wait_req(0);

    // same-cycle read issue and response leaves the count at 3
    resp(0);
    mem_req_ready = 1'b0;
    exp_req.push_back(rq(1'b0, AW'('h800), 0));
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h800);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req_valid && n < 50);
    chk("same_cyc_req", 64'(mem_req_valid), 64'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_tag = TW'(2);
    @(negedge clk);
    chk("same_cyc_resp", 64'(o_resp_valid), 64'b100);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; v_req_valid[0] = 1'b0;
    exp_req.push_back(rq(1'b0, AW'('h810), 0));
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h810);
    wait_req(0);
    v_req_valid[0] = 1'b1; v_req_addr[0] = AW'('h820);
    expect_blocked("rd_after_same_cyc", 0);
    v_req_valid[0] = 1'b0;

    @(negedge clk);
    chk("sb_req_left", 64'(exp_req.size()), 64'd0);
    chk("sb_beat_left", 64'(exp_off.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
